div_8x4: RTL and testbench
==========================

# div_8x4

Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor, one quotient bit per clock. It produces an 8-bit quotient and a 4-bit remainder. It is the inverse of the 4x4 shift-add multiplier and uses the same start/finish handshake, so a multiplier product can be fed back for round-trip checking. It sits beside the multiplier in the f4s arithmetic set.

## Interface
Parameters: none. Widths are fixed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; returns block to IDLE
- start  input  1  request; sampled only in IDLE
- dividend  input  8  unsigned N; captured on the start edge
- divisor  input  4  unsigned D; captured on the start edge
- quotient  output  8  registered N / D
- remainder  output  4  registered N mod D
- busy  output  1  high while iterating (CALC)
- finish  output  1  high in DONE; held until start drops
- div_by_zero  output  1  high with finish when captured D == 0

## Operation
- **Reset values.** All outputs go to 0 and the state goes to IDLE, immediately and independent of clk.
- **States.**
  - IDLE, with start=1: capture N and D.
    - If D == 0: go to DONE.
    - Otherwise: go to CALC, with working quotient Q = N, partial remainder R (5 bits) = 0, and count = 0.
  - CALC: perform one iteration per edge.
    - Compute t = {R[3:0], Q[7]}, then shift Q = {Q[6:0], 0}.
    - If t >= {1'b0, D}: R = t − D and Q[0] = 1. Otherwise R = t.
    - count increments. On the 8th CALC edge, go to DONE.
  - DONE: hold finish=1. Stay while start=1. Go to IDLE on the first edge with start=0.
- **Result load.** quotient, remainder and div_by_zero load on the edge that enters DONE and hold until the next DONE entry or reset.
- **Divide by zero.** quotient = 8'hFF, remainder = 4'h0, div_by_zero = 1.
- **Non-zero divisor.** div_by_zero = 0.
- **Invariants.**
  - R < D after every iteration, so remainder is R[3:0] and R[4] is always 0 at DONE.
  - For D != 0: quotient*D + remainder == N.
- **Input handling.** Changes to dividend or divisor after the capture edge are ignored. start is ignored in CALC and DONE. A new operation needs start to fall (DONE→IDLE) and then rise again.
- **Reset mid-operation.** Reset in CALC or DONE aborts the operation. Outputs go to 0 and finish is not asserted.

## Timing
- E0 is the IDLE edge that samples start=1.
- **Normal divide.** busy rises after E0 and falls after E8. finish rises after E8, so results are valid 8 edges after capture.
- **Divide by zero.** finish and div_by_zero rise after E0. busy stays 0.
- **finish fall.** finish falls after the first edge in DONE that sees start=0. The earliest next capture is the edge after that.
- **Output sequencing.**
  - busy and finish are never high together.
  - quotient and remainder do not toggle during CALC. The partial values stay internal.
- **Throughput.** 10 cycles minimum per operation: 1 capture, 8 CALC edges, 1 DONE exit.

## Test plan
- Hold reset=1 for 40 ns, apply N=154 and D=11, release reset, then start=1 → after 8 CALC edges finish=1, quotient=14, remainder=0, div_by_zero=0. Drop start on finish → finish=0 one edge later.
- N=200, D=7 → quotient=28, remainder=4. N=5, D=9 → quotient=0, remainder=5. N=255, D=1 → quotient=255, remainder=0. N=255, D=15 → quotient=17, remainder=0.
- N=100, D=0 → finish and div_by_zero high one edge after E0, quotient=8'hFF, remainder=0, busy never high.
- Change dividend and divisor each cycle during CALC after capturing N=154, D=11 → result still 14 r 0. Keep start high after finish → block stays in DONE and no new capture occurs.
- Assert reset asynchronously (mid-cycle) after E4 of N=200, D=7 → all outputs 0 immediately, and finish stays 0 after release. A following start with N=200, D=7 → 28 r 4.
- Exhaustive: all 256×15 non-zero (N, D) pairs back-to-back → quotient*D + remainder == N and remainder < D, with each finish exactly 8 edges after capture.

Source files
------------

// File: rtl/div_8x4_if.sv
// Start/finish handshake and operand/result bus of the 8-by-4 restoring divider.
// The requester drives the operands and start; the divider returns registered results.
interface div_8x4_if;
  localparam int unsigned NW = 8;
  localparam int unsigned DW = 4;

  logic          start;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          busy;
  logic          finish;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, finish, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, finish, div_by_zero
  );
endinterface

// File: rtl/div_8x4.sv
// Sequential restoring divider: 8-bit N / 4-bit D, one quotient bit per clock.
// Results stay registered from DONE entry until the next DONE entry or reset.
module div_8x4 (
  input logic      clk,
  input logic      reset,
  div_8x4_if.slave bus
);
  localparam int unsigned NW = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [NW-1:0] q_work;
  logic [DW-1:0] r_work;
  logic [DW-1:0] d_reg;
  logic [CW-1:0] count;

  logic [DW:0]   t;
  logic [DW:0]   diff;
  logic          step_ge;
  logic [DW-1:0] r_step;
  logic [NW-1:0] q_step;

  // One restoring step. The partial remainder always stays below D, so only its
  // low DW bits are stored; the borrow out of t - D decides the quotient bit.
  always_comb begin
    t       = {r_work, q_work[NW-1]};
    diff    = t - {1'b0, d_reg};
    step_ge = ~diff[DW];
    r_step  = step_ge ? diff[DW-1:0] : t[DW-1:0];
    q_step  = {q_work[NW-2:0], step_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      q_work          <= '0;
      r_work          <= '0;
      d_reg           <= '0;
      count           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.finish      <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_work <= bus.dividend;
            d_reg  <= bus.divisor;
            r_work <= '0;
            count  <= '0;
            if (bus.divisor == DW'(0)) begin
              state           <= DONE;
              bus.finish      <= 1'b1;
              bus.div_by_zero <= 1'b1;
              bus.quotient    <= NW'(8'hFF);
              bus.remainder   <= '0;
            end else begin
              state    <= CALC;
              bus.busy <= 1'b1;
            end
          end
        end

        CALC: begin
          q_work <= q_step;
          r_work <= r_step;
          count  <= count + CW'(1);
          // Eighth iteration: publish results and hand over from busy to finish.
          if (count == CW'(7)) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.finish      <= 1'b1;
            bus.quotient    <= q_step;
            bus.remainder   <= r_step;
            bus.div_by_zero <= 1'b0;
          end
        end

        DONE: begin
          if (!bus.start) begin
            state      <= IDLE;
            bus.finish <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          bus.busy   <= 1'b0;
          bus.finish <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_8x4.sv
// Self-checking bench for div_8x4: directed, random and exhaustive divides
// compared with plain integer division.
module tb_div_8x4;
  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  div_8x4_if bus ();

  div_8x4 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one divide, follow it to finish, optionally hold start in DONE, then release.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                        input bit scramble, input int hold);
    int         ni;
    int         di;
    int         lat;
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic [7:0] prev_q;
    logic [3:0] prev_r;
    ni = int'(n);
    di = int'(d);
    if (di == 0) begin
      exp_q = 8'hFF;
      exp_r = 4'h0;
    end else begin
      exp_q = 8'(ni / di);
      exp_r = 4'(ni % di);
    end
    prev_q = bus.quotient;
    prev_r = bus.remainder;
    bus.dividend = n;
    bus.divisor  = d;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    if (di == 0) begin
      check("dz_finish", 32'(bus.finish), 32'd1);
      check("dz_flag", 32'(bus.div_by_zero), 32'd1);
      check("dz_busy", 32'(bus.busy), 32'd0);
      check("dz_quotient", 32'(bus.quotient), 32'hFF);
      check("dz_remainder", 32'(bus.remainder), 32'd0);
    end else begin
      check("busy_after_e0", 32'(bus.busy), 32'd1);
      check("finish_after_e0", 32'(bus.finish), 32'd0);
      lat = 0;
      while (!bus.finish && lat < 20) begin
        check("calc_busy", 32'(bus.busy), 32'd1);
        check("calc_q_hold", 32'(bus.quotient), 32'(prev_q));
        check("calc_r_hold", 32'(bus.remainder), 32'(prev_r));
        if (scramble) begin
          bus.dividend = 8'($urandom);
          bus.divisor  = 4'($urandom);
        end
        @(posedge clk); #1;
        lat++;
      end
      check("latency", 32'(lat), 32'd8);
      check("done_busy", 32'(bus.busy), 32'd0);
      check("quotient", 32'(bus.quotient), 32'(exp_q));
      check("remainder", 32'(bus.remainder), 32'(exp_r));
      check("div_by_zero", 32'(bus.div_by_zero), 32'd0);
      check("identity", 32'(int'(bus.quotient) * di + int'(bus.remainder)), 32'(ni));
      check("rem_lt_div", 32'(int'(bus.remainder) < di), 32'd1);
    end
    repeat (hold) begin
      if (scramble) begin
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
      end
      @(posedge clk); #1;
      check("hold_finish", 32'(bus.finish), 32'd1);
      check("hold_busy", 32'(bus.busy), 32'd0);
      check("hold_quotient", 32'(bus.quotient), 32'(exp_q));
      check("hold_remainder", 32'(bus.remainder), 32'(exp_r));
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("finish_fall", 32'(bus.finish), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd154;
    bus.divisor  = 4'd11;

    #20;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    #20;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(8'd154, 4'd11, 1'b0, 0);
    run_op(8'd200, 4'd7,  1'b0, 0);
    run_op(8'd5,   4'd9,  1'b0, 0);
    run_op(8'd255, 4'd1,  1'b0, 0);
    run_op(8'd255, 4'd15, 1'b0, 0);
    run_op(8'd100, 4'd0,  1'b0, 3);
    run_op(8'd154, 4'd11, 1'b1, 4);

    // Asynchronous reset mid-cycle after E4 of 200 / 7.
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_finish", 32'(bus.finish), 32'd0);
    check("arst_quotient", 32'(bus.quotient), 32'd0);
    check("arst_remainder", 32'(bus.remainder), 32'd0);
    check("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    #10;
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      check("post_rst_finish", 32'(bus.finish), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    run_op(8'd200, 4'd7, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    for (int n = 0; n < 256; n++) begin
      for (int d = 1; d < 16; d++) begin
        run_op(8'(n), 4'(d), 1'b0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
